// File: rtl/move_scheduler.sv
// Piece-movement sequencer: arbitrates gravity and keyboard requests, bounds-checks, issues one move command at a time.
// Latency: request sampled at edge N pends, cmd_valid is high after N+1, handshake at N+2 with cmd_ready held high.
// Backpressure: cmd_valid/cmd_op are held until cmd_ready; new requests keep pending meanwhile.
//
// Ports:
//   clock, resetn        system clock, synchronous active-low reset
//   key_code             PS/2 scan code, non-zero for one cycle per key event
//   grav_tick            one-cycle gravity request
//   cmd_ready            datapath accepts the offered command this cycle
//   cmd_valid, cmd_op    offered command (1=LEFT 2=RIGHT 3=DOWN 4=SPAWN, 0 when idle)
//   piece_row, piece_col current piece position
//   landed               one-cycle pulse after a SPAWN handshake
//   reject               one-cycle pulse when an out-of-field move is discarded
module move_scheduler #(
    parameter int COLS      = 20,
    parameter int ROWS      = 20,
    parameter int SPAWN_COL = 9,
    parameter int LOCKOUT   = 5000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] key_code,
    input  logic       grav_tick,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_op,
    output logic [4:0] piece_row,
    output logic [4:0] piece_col,
    output logic       landed,
    output logic       reject
);
    localparam int CW = $clog2(LOCKOUT + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_DOWN  = 3'd3;
    localparam logic [2:0] OP_SPAWN = 3'd4;

    logic [0:0]    r_state;
    logic [2:0]    r_op;
    logic          r_srv_grav;     // which pending bit the offered command serves
    logic          r_key_pend;
    logic [2:0]    r_key_op;
    logic          r_grav_pend;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_row;
    logic [4:0]    r_col;
    logic          r_landed;
    logic          r_reject;

    logic [2:0]    w_dec;
    logic          w_key_acc;
    logic          w_hs;
    logic          w_at_bottom;
    logic          w_issue;
    logic [2:0]    w_next_op;
    logic          w_next_srv_grav;
    logic          w_rej;
    logic          w_clr_key;
    logic          w_clr_grav;

    always_comb begin
        w_dec = OP_NONE;
        case (key_code)
            8'h1C:   w_dec = OP_LEFT;
            8'h23:   w_dec = OP_RIGHT;
            8'h1B:   w_dec = OP_DOWN;
            default: w_dec = OP_NONE;
        endcase
    end

    // Unrecognised codes never reach the lockout counter.
    assign w_key_acc   = (w_dec != OP_NONE) && (r_cnt == '0) && !r_key_pend;
    assign w_hs        = (r_state == S_ISSUE) && cmd_ready;
    assign w_at_bottom = (r_row == 5'(ROWS - 1));

    always_comb begin
        w_issue         = 1'b0;
        w_next_op       = OP_NONE;
        w_next_srv_grav = 1'b0;
        w_rej           = 1'b0;
        w_clr_key       = 1'b0;
        w_clr_grav      = 1'b0;
        if (r_state == S_IDLE) begin
            if (r_grav_pend) begin
                w_issue         = 1'b1;
                w_next_srv_grav = 1'b1;
                w_next_op       = w_at_bottom ? OP_SPAWN : OP_DOWN;
            end else if (r_key_pend) begin
                if ((r_key_op == OP_LEFT  && r_col == 5'd0) ||
                    (r_key_op == OP_RIGHT && r_col == 5'(COLS - 1))) begin
                    w_rej     = 1'b1;
                    w_clr_key = 1'b1;
                end else begin
                    w_issue   = 1'b1;
                    w_next_op = (r_key_op == OP_DOWN) ? (w_at_bottom ? OP_SPAWN : OP_DOWN)
                                                      : r_key_op;
                end
            end
        end else if (cmd_ready) begin
            // A respawn discards whatever else was queued against the old piece.
            if (r_op == OP_SPAWN) begin
                w_clr_key  = 1'b1;
                w_clr_grav = 1'b1;
            end else if (r_srv_grav) begin
                w_clr_grav = 1'b1;
            end else begin
                w_clr_key  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_op        <= OP_NONE;
            r_srv_grav  <= 1'b0;
            r_key_pend  <= 1'b0;
            r_key_op    <= OP_NONE;
            r_grav_pend <= 1'b0;
            r_cnt       <= '0;
            r_row       <= 5'd0;
            r_col       <= 5'(SPAWN_COL);
            r_landed    <= 1'b0;
            r_reject    <= 1'b0;
        end else begin
            r_landed    <= w_hs && (r_op == OP_SPAWN);
            r_reject    <= w_rej;
            // A tick on the clearing edge is a fresh request, so set wins.
            r_grav_pend <= grav_tick | (r_grav_pend & ~w_clr_grav);
            r_key_pend  <= w_key_acc | (r_key_pend & ~w_clr_key);

            if (w_key_acc) begin
                r_key_op <= w_dec;
                r_cnt    <= CW'(LOCKOUT);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_issue) begin
                r_state    <= S_ISSUE;
                r_op       <= w_next_op;
                r_srv_grav <= w_next_srv_grav;
            end else if (w_hs) begin
                r_state <= S_IDLE;
                r_op    <= OP_NONE;
                case (r_op)
                    OP_LEFT:  r_col <= r_col - 5'd1;
                    OP_RIGHT: r_col <= r_col + 5'd1;
                    OP_DOWN:  r_row <= r_row + 5'd1;
                    OP_SPAWN: begin
                        r_row <= 5'd0;
                        r_col <= 5'(SPAWN_COL);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_valid = (r_state == S_ISSUE);
    assign cmd_op    = cmd_valid ? r_op : OP_NONE;
    assign piece_row = r_row;
    assign piece_col = r_col;
    assign landed    = r_landed;
    assign reject    = r_reject;
endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: inputs driven at negedge, outputs compared at the following negedge.
// Backpressure: cmd_ready is driven per cycle, randomly deasserted in the random phase.
module tb_move_scheduler;
    localparam int LK = 8;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       grav_tick = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [4:0] piece_row;
    logic [4:0] piece_col;
    logic       landed;
    logic       reject;

    int vectors = 0;
    int errors  = 0;

    // Reference model: pending requests, lockout time left, command on offer.
    int m_row, m_col, m_cnt, m_kop, m_offer;
    bit m_kp, m_gp, m_srv_grav, m_landed, m_reject;

    move_scheduler #(.COLS(20), .ROWS(20), .SPAWN_COL(9), .LOCKOUT(LK)) dut (
        .clock(clock), .resetn(resetn), .key_code(key_code), .grav_tick(grav_tick),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .piece_row(piece_row), .piece_col(piece_col), .landed(landed), .reject(reject)
    );

    always #5 clock = ~clock;

    task automatic model_edge(input logic [7:0] k, input bit t, input bit r, input bit rst);
        int dec;
        bit acc, kp_n, gp_n;
        if (rst) begin
            m_row = 0; m_col = 9; m_cnt = 0; m_kop = 0; m_offer = 0;
            m_kp = 0; m_gp = 0; m_srv_grav = 0; m_landed = 0; m_reject = 0;
            return;
        end
        dec = (k == 8'h1C) ? 1 : (k == 8'h23) ? 2 : (k == 8'h1B) ? 3 : 0;
        acc = (dec != 0) && (m_cnt == 0) && !m_kp;
        kp_n = m_kp; gp_n = m_gp; m_landed = 0; m_reject = 0;
        if (m_offer != 0) begin
            if (r) begin
                case (m_offer)
                    1: m_col--;
                    2: m_col++;
                    3: m_row++;
                    default: begin m_row = 0; m_col = 9; kp_n = 0; gp_n = 0; m_landed = 1; end
                endcase
                if (m_offer != 4) begin
                    if (m_srv_grav) gp_n = 0; else kp_n = 0;
                end
                m_offer = 0;
            end
        end else if (m_gp) begin
            m_srv_grav = 1;
            m_offer = (m_row < 19) ? 3 : 4;
        end else if (m_kp) begin
            m_srv_grav = 0;
            if ((m_kop == 1 && m_col == 0) || (m_kop == 2 && m_col == 19)) begin
                m_reject = 1; kp_n = 0;
            end else if (m_kop == 3) m_offer = (m_row < 19) ? 3 : 4;
            else m_offer = m_kop;
        end
        m_cnt = acc ? LK : (m_cnt > 0 ? m_cnt - 1 : 0);
        if (acc) begin kp_n = 1; m_kop = dec; end
        m_kp = kp_n;
        m_gp = gp_n | t;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at the next negedge.
    task automatic step(input logic [7:0] k, input bit t, input bit r, input bit rst);
        key_code = k; grav_tick = t; cmd_ready = r; resetn = ~rst;
        @(posedge clock);
        model_edge(k, t, r, rst);
        @(negedge clock);
        key_code = 8'h00; grav_tick = 1'b0; resetn = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 0, 1, 0);
    endtask

    task automatic do_reset();
        step(8'h00, 0, 1, 1);
        step(8'h00, 0, 1, 1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin step(8'h00, 1, 1, 0); idle(3); end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", cmd_valid); end
        vectors++; if (cmd_op !== 3'd0) begin errors++; $display("FAIL reset_op got %0d exp 0", cmd_op); end
        vectors++; if (piece_row !== 5'd0) begin errors++; $display("FAIL reset_row got %0d exp 0", piece_row); end
        vectors++; if (piece_col !== 5'd9) begin errors++; $display("FAIL reset_col got %0d exp 9", piece_col); end
        vectors++; if ({landed, reject} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {landed, reject}); end
    endtask

    task automatic test_right_key();
        do_reset();
        step(8'h23, 0, 1, 0);
        vectors++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL right_early got %b exp 0", cmd_valid); end
        step(8'h00, 0, 1, 0);
        vectors++; if ({cmd_valid, cmd_op} !== 4'b1_010) begin errors++; $display("FAIL right_issue got %b/%0d exp 1/2", cmd_valid, cmd_op); end
        step(8'h00, 0, 1, 0);
        vectors++; if (cmd_valid !== 1'b0 || piece_col !== 5'd10) begin errors++; $display("FAIL right_done got v%b col%0d exp v0 col10", cmd_valid, piece_col); end
    endtask

    task automatic test_lockout();
        do_reset();
        step(8'h1C, 0, 1, 0);
        idle(2);
        step(8'h1C, 0, 1, 0);
        idle(10);
        vectors++; if (piece_col !== 5'd8) begin errors++; $display("FAIL lockout_drop got %0d exp 8", piece_col); end
        step(8'h1C, 0, 1, 0);
        idle(3);
        vectors++; if (piece_col !== 5'd7) begin errors++; $display("FAIL lockout_expire got %0d exp 7", piece_col); end
    endtask

    task automatic test_left_boundary();
        do_reset();
        for (int i = 0; i < 9; i++) begin step(8'h1C, 0, 1, 0); idle(9); end
        vectors++; if (piece_col !== 5'd0) begin errors++; $display("FAIL left_walk got %0d exp 0", piece_col); end
        step(8'h1C, 0, 1, 0);
        step(8'h00, 0, 1, 0);
        vectors++; if ({reject, cmd_valid} !== 2'b10) begin errors++; $display("FAIL left_reject got rej%b v%b exp rej1 v0", reject, cmd_valid); end
        step(8'h00, 0, 1, 0);
        vectors++; if ({reject, cmd_valid} !== 2'b00 || piece_col !== 5'd0) begin errors++; $display("FAIL left_after got rej%b v%b col%0d exp 0 0 0", reject, cmd_valid, piece_col); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ticks(5);
        step(8'h1B, 1, 1, 0);
        step(8'h00, 0, 1, 0);
        vectors++; if ({cmd_valid, cmd_op} !== 4'b1_011 || piece_row !== 5'd5) begin errors++; $display("FAIL simul_first got v%b op%0d row%0d exp 1 3 5", cmd_valid, cmd_op, piece_row); end
        step(8'h00, 0, 1, 0);
        vectors++; if (piece_row !== 5'd6) begin errors++; $display("FAIL simul_mid got %0d exp 6", piece_row); end
        step(8'h00, 0, 1, 0);
        vectors++; if ({cmd_valid, cmd_op} !== 4'b1_011) begin errors++; $display("FAIL simul_second got v%b op%0d exp 1 3", cmd_valid, cmd_op); end
        step(8'h00, 0, 1, 0);
        vectors++; if (piece_row !== 5'd7) begin errors++; $display("FAIL simul_final got %0d exp 7", piece_row); end
    endtask

    task automatic test_spawn();
        do_reset();
        ticks(19);
        vectors++; if (piece_row !== 5'd19) begin errors++; $display("FAIL spawn_bottom got %0d exp 19", piece_row); end
        step(8'h00, 1, 1, 0);
        step(8'h00, 0, 1, 0);
        vectors++; if ({cmd_valid, cmd_op} !== 4'b1_100) begin errors++; $display("FAIL spawn_op got v%b op%0d exp 1 4", cmd_valid, cmd_op); end
        step(8'h00, 0, 1, 0);
        vectors++; if (landed !== 1'b1 || piece_row !== 5'd0 || piece_col !== 5'd9) begin errors++; $display("FAIL spawn_done got l%b row%0d col%0d exp 1 0 9", landed, piece_row, piece_col); end
        step(8'h00, 0, 1, 0);
        vectors++; if (landed !== 1'b0) begin errors++; $display("FAIL spawn_pulse got %b exp 0", landed); end
    endtask

    task automatic test_stall();
        do_reset();
        step(8'h1C, 0, 0, 0);
        step(8'h00, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(8'h00, i == 2, 0, 0);
            vectors++; if ({cmd_valid, cmd_op} !== 4'b1_001 || piece_col !== 5'd9) begin errors++; $display("FAIL stall_hold got v%b op%0d col%0d exp 1 1 9", cmd_valid, cmd_op, piece_col); end
        end
        step(8'h00, 0, 1, 0);
        vectors++; if (cmd_valid !== 1'b0 || piece_col !== 5'd8) begin errors++; $display("FAIL stall_hs got v%b col%0d exp 0 8", cmd_valid, piece_col); end
        step(8'h00, 0, 1, 0);
        vectors++; if ({cmd_valid, cmd_op} !== 4'b1_011) begin errors++; $display("FAIL stall_grav got v%b op%0d exp 1 3", cmd_valid, cmd_op); end
        step(8'h00, 0, 1, 0);
        vectors++; if (piece_row !== 5'd1) begin errors++; $display("FAIL stall_row got %0d exp 1", piece_row); end
    endtask

    task automatic test_reset_in_stall();
        do_reset();
        step(8'h23, 0, 0, 0);
        step(8'h00, 0, 0, 0);
        vectors++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rststall_valid got %b exp 1", cmd_valid); end
        step(8'h00, 0, 0, 1);
        vectors++; if ({cmd_valid, cmd_op, piece_row, piece_col, landed, reject} !== {1'b0, 3'd0, 5'd0, 5'd9, 2'b00})
            begin errors++; $display("FAIL rststall_outs got v%b op%0d row%0d col%0d exp 0 0 0 9", cmd_valid, cmd_op, piece_row, piece_col); end
        step(8'h00, 0, 1, 0);
        vectors++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rststall_drop got %b exp 0", cmd_valid); end
    endtask

    task automatic test_random();
        logic [7:0]  k;
        logic [15:0] got_v, exp_v;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            case ($urandom % 8)
                4: k = 8'h1C;
                5: k = 8'h23;
                6: k = 8'h1B;
                7: k = 8'h5A;
                default: k = 8'h00;
            endcase
            step(k, ($urandom % 6) == 0, ($urandom % 4) != 0, ($urandom % 700) == 0);
            got_v = {cmd_valid, cmd_op, piece_row, piece_col, landed, reject};
            exp_v = {m_offer != 0, 3'(m_offer), 5'(m_row), 5'(m_col), m_landed, m_reject};
            vectors++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random cycle %0d got v%b op%0d r%0d c%0d l%b j%b exp v%b op%0d r%0d c%0d l%b j%b",
                         i, got_v[15], got_v[14:12], got_v[11:7], got_v[6:2], got_v[1], got_v[0],
                         exp_v[15], exp_v[14:12], exp_v[11:7], exp_v[6:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_right_key();
        test_lockout();
        test_left_boundary();
        test_simultaneous();
        test_spawn();
        test_stall();
        test_reset_in_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Sequences all piece-movement updates for the 20x20 playfield register.
- Arbitrates between keyboard scan-code requests and the periodic gravity tick, then issues one move command at a time to the field datapath over a valid/ready handshake.
- Tracks the piece position, rejects moves that would leave the field, and issues a respawn command when the piece lands on the bottom row.
- Rate-limits accepted keys to one per lockout window.

Parameters:
- COLS, 20, field width in cells.
- ROWS, 20, field height in cells; row 0 is the top row.
- SPAWN_COL, 9, column the piece occupies after reset and after each respawn.
- LOCKOUT, 5000000, clock cycles after an accepted key during which further keys are ignored (100 ms at 50 MHz).

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- key_code  in  8  PS/2 scan code; a non-zero value is a one-cycle key event
- grav_tick  in  1  one-cycle gravity request pulse
- cmd_ready  in  1  field datapath can accept a command this cycle
- cmd_valid  out  1  command offered to the datapath
- cmd_op  out  3  1=LEFT, 2=RIGHT, 3=DOWN, 4=SPAWN, 0=none
- piece_row  out  5  current piece row
- piece_col  out  5  current piece column
- landed  out  1  one-cycle pulse on SPAWN handshake
- reject  out  1  one-cycle pulse when a boundary-violating request is discarded

Behaviour:
- Reset: reset is resetn, synchronous, active-low; clock is clock.
  - On reset: cmd_valid=0, cmd_op=0, piece_row=0, piece_col=SPAWN_COL, landed=0, reject=0.
  - Also cleared: lockout counter=0, key_pend=0, grav_pend=0, FSM=IDLE.
  - No SPAWN is issued after reset; the datapath resets to the same spawn position.
  - Reset mid-ISSUE drops the pending command immediately; cmd_valid is low on the next cycle.
- Key decode:
  - 8'h1C=LEFT, 8'h23=RIGHT, 8'h1B=DOWN.
  - Any other non-zero code is ignored and does not start lockout.
- Key accept:
  - A recognised code is accepted when lockout counter==0 and key_pend==0.
  - Accept latches key_pend and key_op and loads the counter with LOCKOUT.
  - The counter decrements by 1 per cycle to 0.
  - Keys arriving while the counter is non-zero or key_pend is set are lost.
- Gravity: grav_tick sets grav_pend. A tick arriving while grav_pend is already set merges into it and is not counted twice.
- FSM IDLE:
  - Arbitration priority: grav_pend first, otherwise key_pend.
  - Boundary check on the selected request:
    - LEFT with col==0 is rejected.
    - RIGHT with col==COLS-1 is rejected.
    - Rejection clears that pending bit, pulses reject for 1 cycle, and keeps the FSM in IDLE.
  - DOWN or gravity with row<ROWS-1: go to ISSUE with op=DOWN.
  - DOWN or gravity with row==ROWS-1: go to ISSUE with op=SPAWN.
  - A valid LEFT or RIGHT goes to ISSUE with that op.
- FSM ISSUE:
  - cmd_valid=1 and cmd_op are held stable until cmd_valid&&cmd_ready at a clock edge.
  - On that handshake edge:
    - the served pending bit clears;
    - position updates: LEFT col-1, RIGHT col+1, DOWN row+1, SPAWN row=0 and col=SPAWN_COL;
    - the FSM returns to IDLE.
  - On SPAWN, both key_pend and grav_pend clear and landed pulses in the following cycle.
- Latency: a request sampled at edge N sets its pending bit; cmd_valid is high after edge N+1. With cmd_ready held high, the handshake completes at edge N+2.
- Simultaneous key and tick: both pend; gravity is served first and the key next. The key is re-checked against the updated position.
- cmd_op=0 whenever cmd_valid=0.
- Pending bits may set during ISSUE.
- Positions never leave the range 0..COLS-1 and 0..ROWS-1.

Test Plan (all with LOCKOUT=8 in simulation):
- Reset, then key_code=8'h23 one cycle with cmd_ready=1 -> cmd_valid high one cycle, op=2, then piece_col=10.
- Two 8'h1C keys 3 cycles apart -> only the first is issued and piece_col=8; the same key 9+ cycles later -> piece_col=7.
- piece_col=0, key 8'h1C -> reject pulse, no cmd_valid, piece_col stays 0.
- grav_tick and 8'h1B in the same cycle at row 5 -> two DOWN commands, gravity first; final piece_row=7.
- piece_row=19, grav_tick -> op=4 SPAWN; after handshake piece_row=0, piece_col=9, landed pulses once.
- cmd_ready=0 for 5 cycles while op=1 is issued -> cmd_valid and op held stable; a grav_tick during the stall is served after the handshake. Reset during a stall -> all outputs return to reset values the next cycle.
